// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit that owns the HI/LO registers.
// One iteration per cycle: shift-add for multiply, restoring division for divide.
//
// state | meaning
// IDLE  | waiting for start; mthi/mtlo writes accepted
// RUN   | WIDTH iterations, count 0..WIDTH-1
// FIN   | sign correction, commit to hi/lo, done pulses next cycle
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mthi,
   input  logic             mtlo,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      count_q, count_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic               is_div_q, is_div_d;
   logic               neg_q, neg_d;
   logic               neg_rem_q, neg_rem_d;
   logic               div0_q, div0_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               signed_op, a_neg, b_neg, accept, rem_ge;
   logic [WIDTH-1:0]   a_mag, b_mag, quot, rem, quot_f, rem_f;
   logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;
   logic [2*WIDTH-1:0] prod;

   always_comb begin
      signed_op = ~op[0];
      a_neg     = signed_op & a[WIDTH-1];
      b_neg     = signed_op & b[WIDTH-1];
      a_mag     = a_neg ? -a : a;
      b_mag     = b_neg ? -b : b;
      // FIN doubles as an accept slot so back-to-back ops lose no cycle
      accept    = start && (state_q == IDLE || state_q == FIN);

      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
               + {1'b0, (acc_q[0] ? mcand_q : {WIDTH{1'b0}})};
      rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
      rem_diff = rem_sh - {1'b0, mcand_q};
      rem_ge   = (rem_sh >= {1'b0, mcand_q});

      prod   = neg_q ? -acc_q : acc_q;
      quot   = acc_q[WIDTH-1:0];
      rem    = acc_q[2*WIDTH-1:WIDTH];
      quot_f = neg_q ? -quot : quot;
      rem_f  = neg_rem_q ? -rem : rem;

      state_d   = state_q;
      count_d   = count_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      is_div_d  = is_div_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      div0_d    = div0_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (!start) begin
               if (mthi) hi_d = a;
               if (mtlo) lo_d = a;
            end
         end
         RUN: begin
            if (is_div_q) begin
               acc_d = {(rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], rem_ge};
            end else begin
               acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
            count_d = count_q + CW'(1);
            if (count_q == LAST) state_d = FIN;
         end
         FIN: begin
            if (is_div_q) begin
               hi_d = rem_f;
               // divide by zero leaves the remainder equal to the dividend on its own
               lo_d = div0_q ? {WIDTH{1'b1}} : quot_f;
            end else begin
               {hi_d, lo_d} = prod;
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         state_d   = RUN;
         count_d   = '0;
         is_div_d  = op[1];
         neg_d     = a_neg ^ b_neg;
         neg_rem_d = a_neg;
         div0_d    = (b == {WIDTH{1'b0}});
         mcand_d   = op[1] ? b_mag : a_mag;
         acc_d     = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         count_q   <= '0;
         acc_q     <= '0;
         mcand_q   <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         is_div_q  <= is_div_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         div0_q    <= div0_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
